// File: rtl/cpu_ctrl_pkg.sv
// Shared control-path definitions for the 5-stage RISC-V core: sequencer
// states, decoder opcodes, register-index width and the hazard control bundle.
package cpu_ctrl_pkg;

   localparam int unsigned REG_W = 5;
   localparam int unsigned OPC_W = 7;

   // Sequencer states
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE     = 2'd0;
   localparam state_t ST_RUN      = 2'd1;
   localparam state_t ST_MEM_WAIT = 2'd2;
   localparam state_t ST_ERR      = 2'd3;

   // Opcodes shared with the main control decoder
   localparam logic [OPC_W-1:0] OP_R   = 7'b0110011;
   localparam logic [OPC_W-1:0] OP_I   = 7'b0010011;
   localparam logic [OPC_W-1:0] OP_LW  = 7'b0000011;
   localparam logic [OPC_W-1:0] OP_SW  = 7'b0100011;
   localparam logic [OPC_W-1:0] OP_BEQ = 7'b1100011;

   // Pipeline steering bundle driven by the sequencer
   typedef struct packed {
      logic pc_write;
      logic ifid_write;
      logic noop;
      logic flush;
      logic freeze;
   } ctrl_t;

   localparam ctrl_t CTRL_HALT   = '{pc_write: 1'b0, ifid_write: 1'b0, noop: 1'b1, flush: 1'b0, freeze: 1'b1};
   localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, ifid_write: 1'b0, noop: 1'b0, flush: 1'b0, freeze: 1'b1};
   localparam ctrl_t CTRL_BUBBLE = '{pc_write: 1'b0, ifid_write: 1'b0, noop: 1'b1, flush: 1'b0, freeze: 1'b0};
   localparam ctrl_t CTRL_FLUSH  = '{pc_write: 1'b1, ifid_write: 1'b1, noop: 1'b0, flush: 1'b1, freeze: 1'b0};
   localparam ctrl_t CTRL_FLOW   = '{pc_write: 1'b1, ifid_write: 1'b1, noop: 1'b0, flush: 1'b0, freeze: 1'b0};

   // Flowing-pipeline priority: a load-use bubble wins over a taken-branch flush
   function automatic ctrl_t run_ctrl(input logic lu, input logic branch_taken);
      run_ctrl = CTRL_FLOW;
      if (lu) begin
         run_ctrl = CTRL_BUBBLE;
      end else if (branch_taken) begin
         run_ctrl = CTRL_FLUSH;
      end
   endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use comparator: the load in EX writes a register the ID instruction reads.
module load_use_detect
   import cpu_ctrl_pkg::*;
(
   input  logic             idex_mem_read_i,
   input  logic [REG_W-1:0] idex_rd_i,
   input  logic [REG_W-1:0] ifid_rs1_i,
   input  logic [REG_W-1:0] ifid_rs2_i,
   output logic             lu_c_o
);

   logic rd_nz;
   logic rd_hit;

   // x0 is never a real dependency
   assign rd_nz  = (idex_rd_i != REG_W'(0));
   assign rd_hit = (idex_rd_i == ifid_rs1_i) || (idex_rd_i == ifid_rs2_i);
   assign lu_c_o = idex_mem_read_i & rd_nz & rd_hit;

endmodule

// File: rtl/pipe_hazard_sequencer.sv
// Stall/flush/freeze sequencer for the 5-stage core with memory-wait watchdog.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module pipe_hazard_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CNT_W   = 8
`ifdef HAZARD_PERF_EN
   ,
   parameter int unsigned PERF_W  = 32
`endif
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             IDEX_MemRead_i,
   input  logic [REG_W-1:0] IDEX_rd_i,
   input  logic [REG_W-1:0] IFID_rs1_i,
   input  logic [REG_W-1:0] IFID_rs2_i,
   input  logic             branch_taken_i,
   input  logic             mem_req_i,
   input  logic             mem_ack_i,
   output logic             PCWrite_o,
   output logic             IFIDWrite_o,
   output logic             NoOp_o,
   output logic             Flush_o,
   output logic             Freeze_o,
   output logic             mem_err_o
`ifdef HAZARD_PERF_EN
   ,
   output logic [PERF_W-1:0] stall_cnt_o,
   output logic [PERF_W-1:0] bubble_cnt_o,
   output logic [PERF_W-1:0] flush_cnt_o
`endif
);

   localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   ctrl_t            ctrl_c;
   logic             lu_c;

   load_use_detect u_load_use_detect (
      .idex_mem_read_i (IDEX_MemRead_i),
      .idex_rd_i       (IDEX_rd_i),
      .ifid_rs1_i      (IFID_rs1_i),
      .ifid_rs2_i      (IFID_rs2_i),
      .lu_c_o          (lu_c)
   );

   // State and wait-counter register
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state, counter and pipeline steering
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ctrl_c  = CTRL_HALT;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (mem_req_i && !mem_ack_i) begin
               ctrl_c  = CTRL_FREEZE;
               state_d = ST_MEM_WAIT;
               cnt_d   = CNT_W'(1);
            end else begin
               ctrl_c = run_ctrl(lu_c, branch_taken_i);
            end
         end
         ST_MEM_WAIT: begin
            if (mem_ack_i) begin
               // mem_req_i still describes the access just acked
               ctrl_c  = run_ctrl(lu_c, branch_taken_i);
               state_d = ST_RUN;
               cnt_d   = '0;
            end else begin
               ctrl_c = CTRL_FREEZE;
               if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
               if (cnt_q == CNT_TIMEOUT) begin
                  state_d = ST_ERR;
               end
            end
         end
         ST_ERR: begin
            ctrl_c = CTRL_HALT;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign PCWrite_o   = ctrl_c.pc_write;
   assign IFIDWrite_o = ctrl_c.ifid_write;
   assign NoOp_o      = ctrl_c.noop;
   assign Flush_o     = ctrl_c.flush;
   assign Freeze_o    = ctrl_c.freeze;
   assign mem_err_o   = (state_q == ST_ERR);

`ifdef HAZARD_PERF_EN
   logic [PERF_W-1:0] stall_q, bubble_q, flush_q;
   logic              exec_c;

   // Only RUN/MEM_WAIT activity is real pipeline work
   assign exec_c = (state_q == ST_RUN) || (state_q == ST_MEM_WAIT);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stall_q  <= '0;
         bubble_q <= '0;
         flush_q  <= '0;
      end else begin
         if (exec_c && ctrl_c.freeze) begin
            stall_q <= stall_q + PERF_W'(1);
         end
         if (exec_c && ctrl_c.noop) begin
            bubble_q <= bubble_q + PERF_W'(1);
         end
         if (exec_c && ctrl_c.flush) begin
            flush_q <= flush_q + PERF_W'(1);
         end
      end
   end

   assign stall_cnt_o  = stall_q;
   assign bubble_cnt_o = bubble_q;
   assign flush_cnt_o  = flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_sequencer.sv
// Directed scoreboard bench for pipe_hazard_sequencer (TIMEOUT = 4).
module tb_pipe_hazard_sequencer;
   import cpu_ctrl_pkg::*;

   localparam int unsigned TO = 4;

   logic             clk_i = 1'b0;
   logic             rst_i = 1'b0;
   logic             start_i = 1'b0;
   logic             IDEX_MemRead_i = 1'b0;
   logic [REG_W-1:0] IDEX_rd_i = '0;
   logic [REG_W-1:0] IFID_rs1_i = '0;
   logic [REG_W-1:0] IFID_rs2_i = '0;
   logic             branch_taken_i = 1'b0;
   logic             mem_req_i = 1'b0;
   logic             mem_ack_i = 1'b0;
   logic             PCWrite_o, IFIDWrite_o, NoOp_o, Flush_o, Freeze_o, mem_err_o;
`ifdef HAZARD_PERF_EN
   logic [31:0]      stall_cnt_o, bubble_cnt_o, flush_cnt_o;
`endif

   pipe_hazard_sequencer #(
      .TIMEOUT (TO),
      .CNT_W   (8)
`ifdef HAZARD_PERF_EN
      ,
      .PERF_W  (32)
`endif
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .start_i        (start_i),
      .IDEX_MemRead_i (IDEX_MemRead_i),
      .IDEX_rd_i      (IDEX_rd_i),
      .IFID_rs1_i     (IFID_rs1_i),
      .IFID_rs2_i     (IFID_rs2_i),
      .branch_taken_i (branch_taken_i),
      .mem_req_i      (mem_req_i),
      .mem_ack_i      (mem_ack_i),
      .PCWrite_o      (PCWrite_o),
      .IFIDWrite_o    (IFIDWrite_o),
      .NoOp_o         (NoOp_o),
      .Flush_o        (Flush_o),
      .Freeze_o       (Freeze_o),
      .mem_err_o      (mem_err_o)
`ifdef HAZARD_PERF_EN
      ,
      .stall_cnt_o    (stall_cnt_o),
      .bubble_cnt_o   (bubble_cnt_o),
      .flush_cnt_o    (flush_cnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   // {PCWrite, IFIDWrite, NoOp, Flush, Freeze, mem_err}
   localparam logic [5:0] E_IDLE   = 6'b001010;
   localparam logic [5:0] E_ERR    = 6'b001011;
   localparam logic [5:0] E_FLOW   = 6'b110000;
   localparam logic [5:0] E_BUBBLE = 6'b001000;
   localparam logic [5:0] E_FLUSH  = 6'b110100;
   localparam logic [5:0] E_FREEZE = 6'b000010;

   typedef struct {
      string      tag;
      logic [5:0] exp;
   } exp_t;

   exp_t       sb_q[$];
   int         checks = 0;
   int         errors = 0;
   int         exp_stall = 0;
   int         exp_bubble = 0;
   int         exp_flush = 0;
   logic [5:0] obs;

   assign obs = {PCWrite_o, IFIDWrite_o, NoOp_o, Flush_o, Freeze_o, mem_err_o};

   task automatic push_exp(input string tag, input logic [5:0] e);
      exp_t item;
      item.tag = tag;
      item.exp = e;
      sb_q.push_back(item);
   endtask

   // Pop one expectation, compare, and tally the expected perf events
   task automatic pop_check();
      exp_t item;
      if (sb_q.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty: observed %b expected <entry>", obs);
         return;
      end
      item = sb_q.pop_front();
      checks++;
      assert (obs === item.exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", item.tag, obs, item.exp);
      end
      if (item.exp[1] && !item.exp[3]) exp_stall++;
      if (item.exp[3] && !item.exp[1]) exp_bubble++;
      if (item.exp[2]) exp_flush++;
   endtask

   // One clock of stimulus: drive after an edge, check on the falling edge
   task automatic drive(input string tag, input logic st, input logic mr,
                        input logic [REG_W-1:0] rd, input logic [REG_W-1:0] rs1,
                        input logic [REG_W-1:0] rs2, input logic br,
                        input logic req, input logic ack, input logic [5:0] e);
      start_i        = st;
      IDEX_MemRead_i = mr;
      IDEX_rd_i      = rd;
      IFID_rs1_i     = rs1;
      IFID_rs2_i     = rs2;
      branch_taken_i = br;
      mem_req_i      = req;
      mem_ack_i      = ack;
      push_exp(tag, e);
      @(negedge clk_i);
      pop_check();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check_perf(input string tag);
`ifdef HAZARD_PERF_EN
      checks++;
      assert (stall_cnt_o === 32'(exp_stall)) else begin
         errors++;
         $error("FAIL %s_stall: observed %0d expected %0d", tag, stall_cnt_o, exp_stall);
      end
      checks++;
      assert (bubble_cnt_o === 32'(exp_bubble)) else begin
         errors++;
         $error("FAIL %s_bubble: observed %0d expected %0d", tag, bubble_cnt_o, exp_bubble);
      end
      checks++;
      assert (flush_cnt_o === 32'(exp_flush)) else begin
         errors++;
         $error("FAIL %s_flush: observed %0d expected %0d", tag, flush_cnt_o, exp_flush);
      end
`else
      if (tag.len() == 0) $display("perf check skipped");
`endif
   endtask

   // Async reset asserted off-edge: outputs must go idle immediately
   task automatic reset_check(input string tag);
      rst_i = 1'b0;
      #2;
      push_exp(tag, E_IDLE);
      pop_check();
      exp_stall  = 0;
      exp_bubble = 0;
      exp_flush  = 0;
      start_i = 1'b0; IDEX_MemRead_i = 1'b0; IDEX_rd_i = '0; IFID_rs1_i = '0;
      IFID_rs2_i = '0; branch_taken_i = 1'b0; mem_req_i = 1'b0; mem_ack_i = 1'b0;
      @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      check_perf({tag, "_perf"});
   endtask

   initial begin
      reset_check("reset");
      drive("idle_hold",      0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, E_IDLE);
      drive("idle_start",     1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, E_IDLE);
      drive("run_normal",     0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, E_FLOW);
      drive("lu_rs1",         0, 1, 5'd5, 5'd5, 5'd1, 0, 0, 0, E_BUBBLE);
      drive("lu_clear",       0, 0, 5'd0, 5'd5, 5'd1, 0, 0, 0, E_FLOW);
      drive("lu_rs2",         0, 1, 5'd7, 5'd2, 5'd7, 0, 0, 0, E_BUBBLE);
      drive("lu_rd0",         0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, E_FLOW);
      drive("lu_no_match",    0, 1, 5'd9, 5'd3, 5'd4, 0, 0, 0, E_FLOW);
      drive("branch",         0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, E_FLUSH);
      drive("branch_lu",      0, 1, 5'd6, 5'd6, 5'd0, 1, 0, 0, E_BUBBLE);
      drive("branch_retry",   0, 0, 5'd0, 5'd6, 5'd0, 1, 0, 0, E_FLUSH);
      drive("zero_wait",      0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, E_FLOW);
      drive("mem_entry",      0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, E_FREEZE);
      drive("mem_wait1",      0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, E_FREEZE);
      drive("mem_wait2",      0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, E_FREEZE);
      drive("mem_ack",        0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, E_FLOW);
      drive("after_ack",      0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, E_FLOW);
      check_perf("perf_mid");
      drive("mem_entry2",     0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, E_FREEZE);
      drive("ack_lu",         0, 1, 5'd8, 5'd0, 5'd8, 1, 1, 1, E_BUBBLE);
      drive("ack_then_br",    0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, E_FLUSH);
      drive("start_ignored",  1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, E_FLOW);
      for (int i = 0; i <= int'(TO); i++) begin
         drive($sformatf("to_freeze%0d", i), 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, E_FREEZE);
      end
      drive("err_enter",      0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, E_ERR);
      drive("err_ack",        0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, E_ERR);
      drive("err_start",      1, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0, E_ERR);
      check_perf("perf_err");
      reset_check("err_reset");
      drive("post_err_idle",  0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, E_IDLE);
      drive("post_err_start", 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, E_IDLE);
      drive("post_err_run",   0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, E_FLOW);
      drive("mid_entry",      0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, E_FREEZE);
      drive("mid_wait",       0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, E_FREEZE);
      check_perf("perf_pre_rst");
      mem_req_i = 1'b1;
      reset_check("rst_midwait");
      drive("restart_idle",   1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, E_IDLE);
      drive("restart_run",    0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, E_FLOW);
      check_perf("perf_end");
      if (sb_q.size() != 0) begin
         errors++;
         $error("FAIL scoreboard_leftover: observed %0d expected 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
